// File: rtl/pc_fetch_if.sv
// Bundle of the fetch-stage signals: stall/redirect controls, instruction ROM bus and IF/ID outputs.
// The slave modport is the fetch unit's view; the master modport is the surrounding pipeline's view.
interface pc_fetch_if;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    modport slave (
        input  stall,
        input  flush,
        input  new_pc,
        input  branch_flag_i,
        input  branch_target_address_i,
        input  inst_i,
        output pc,
        output ce,
        output id_pc,
        output id_inst,
        output id_valid,
        output id_adel
    );

    modport master (
        output stall,
        output flush,
        output new_pc,
        output branch_flag_i,
        output branch_target_address_i,
        output inst_i,
        input  pc,
        input  ce,
        input  id_pc,
        input  id_inst,
        input  id_valid,
        input  id_adel
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and IF/ID pipeline register with flush/stall/branch redirect.
// Every output is a flop; inputs only reach next-state logic.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    pc_fetch_if.slave fetch
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic        r_ce;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_adel;

    logic [0:0]  w_state_next;
    logic        w_ce_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_id_pc_next;
    logic [31:0] w_id_inst_next;
    logic        w_id_valid_next;
    logic        w_id_adel_next;
    logic        w_misaligned;
    logic        w_if_stall;
    logic        w_id_stall;

    assign w_if_stall   = fetch.stall[1];
    assign w_id_stall   = fetch.stall[2];
    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // FSM next state: leave IDLE on the first non-reset clock, then stay in RUN
    always_comb begin
        w_state_next = r_state;
        w_ce_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_RUN;
                w_ce_next    = 1'b1;
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
                w_ce_next    = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ce_next    = 1'b0;
            end
        endcase
    end

    // Next fetch address: flush beats stall, stall beats branch, else sequential
    always_comb begin
        w_pc_next = r_pc;
        if (r_state != ST_RUN) begin
            w_pc_next = RESET_PC;
        end else if (fetch.flush) begin
            w_pc_next = fetch.new_pc;
        end else if (fetch.stall[0]) begin
            w_pc_next = r_pc;
        end else if (fetch.branch_flag_i) begin
            // no alignment check here; misalignment surfaces later as id_adel
            w_pc_next = fetch.branch_target_address_i;
        end else begin
            w_pc_next = r_pc + 32'd4;
        end
    end

    // IF/ID register next value: clear, bubble, capture or hold
    always_comb begin
        w_id_pc_next    = r_id_pc;
        w_id_inst_next  = r_id_inst;
        w_id_valid_next = r_id_valid;
        w_id_adel_next  = r_id_adel;
        if (fetch.flush || (w_if_stall && !w_id_stall)) begin
            w_id_pc_next    = 32'h0000_0000;
            w_id_inst_next  = 32'h0000_0000;
            w_id_valid_next = 1'b0;
            w_id_adel_next  = 1'b0;
        end else if (!w_if_stall && r_ce) begin
            // a misaligned fetch is passed on as a nop tagged with the address error
            w_id_pc_next    = r_pc;
            w_id_inst_next  = w_misaligned ? 32'h0000_0000 : fetch.inst_i;
            w_id_valid_next = 1'b1;
            w_id_adel_next  = w_misaligned;
        end else if (!w_if_stall) begin
            w_id_pc_next    = 32'h0000_0000;
            w_id_inst_next  = 32'h0000_0000;
            w_id_valid_next = 1'b0;
            w_id_adel_next  = 1'b0;
        end else begin
            w_id_pc_next    = r_id_pc;
            w_id_inst_next  = r_id_inst;
            w_id_valid_next = r_id_valid;
            w_id_adel_next  = r_id_adel;
        end
    end

    // State, pc and ROM enable registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ce    <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_ce    <= w_ce_next;
            r_pc    <= w_pc_next;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
            r_id_valid <= 1'b0;
            r_id_adel  <= 1'b0;
        end else begin
            r_id_pc    <= w_id_pc_next;
            r_id_inst  <= w_id_inst_next;
            r_id_valid <= w_id_valid_next;
            r_id_adel  <= w_id_adel_next;
        end
    end

    assign fetch.pc       = r_pc;
    assign fetch.ce       = r_ce;
    assign fetch.id_pc    = r_id_pc;
    assign fetch.id_inst  = r_id_inst;
    assign fetch.id_valid = r_id_valid;
    assign fetch.id_adel  = r_id_adel;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios followed by random stimulus,
// all compared against a cycle-level reference model of the fetch stage.
module tb_pc_fetch;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bus.slave)
    );

    always #5 clk = ~clk;

    // Instruction ROM contents as a pure function of address (never zero)
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[7:0], ~a[7:0], a[15:8] ^ 8'h5A, 8'hC3};
    endfunction

    assign bus.inst_i = rom_word(bus.pc);

    // Reference model state
    logic        m_run;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic        m_id_adel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the expected behaviour, using the inputs held across the edge
    task automatic model_edge();
        logic        clear_id;
        logic [31:0] pc_old;
        pc_old = m_pc;
        if (rst) begin
            m_run = 1'b0; m_pc = 32'h0;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_id_adel = 1'b0;
        end else begin
            clear_id = bus.flush || (bus.stall[1] && !bus.stall[2]) || (!bus.stall[1] && !m_run);
            if (clear_id) begin
                m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_id_adel = 1'b0;
            end else if (!bus.stall[1]) begin
                m_id_pc    = pc_old;
                m_id_adel  = (pc_old % 32'd4) != 32'd0;
                m_id_inst  = m_id_adel ? 32'h0 : rom_word(pc_old);
                m_id_valid = 1'b1;
            end
            if (!m_run)                m_pc = 32'h0;
            else if (bus.flush)        m_pc = bus.new_pc;
            else if (bus.stall[0])     m_pc = pc_old;
            else if (bus.branch_flag_i) m_pc = bus.branch_target_address_i;
            else                       m_pc = pc_old + 32'd4;
            m_run = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] tgt);
        rst = r;
        bus.stall = st; bus.flush = fl; bus.new_pc = npc;
        bus.branch_flag_i = br; bus.branch_target_address_i = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", bus.pc, m_pc);
        chk("ce", {31'd0, bus.ce}, {31'd0, m_run});
        chk("id_pc", bus.id_pc, m_id_pc);
        chk("id_inst", bus.id_inst, m_id_inst);
        chk("id_valid", {31'd0, bus.id_valid}, {31'd0, m_id_valid});
        chk("id_adel", {31'd0, bus.id_adel}, {31'd0, m_id_adel});
    endtask

    initial begin
        m_run = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0;
        m_id_valid = 1'b0; m_id_adel = 1'b0;
        drive(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        step(); step();
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_ce", {31'd0, bus.ce}, 32'd0);

        // reset release and sequential fetch
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("rel_c1_ce", {31'd0, bus.ce}, 32'd1);
        chk("rel_c1_pc", bus.pc, 32'h0);
        step();
        chk("rel_c2_pc", bus.pc, 32'h4);
        chk("rel_c2_id_pc", bus.id_pc, 32'h0);
        chk("rel_c2_inst", bus.id_inst, 32'h00FF_5AC3);
        step();
        chk("seq_pc8", bus.pc, 32'h8);

        // taken branch at pc=0x8
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h40);
        step();
        chk("br_pc", bus.pc, 32'h40);
        chk("br_id_pc", bus.id_pc, 32'h8);

        // redirect to 0xC, then two-cycle PC+IF stall
        drive(1'b0, 6'd0, 1'b1, 32'hC, 1'b0, 32'h0);
        step();
        drive(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        step(); step();
        chk("stall_pc", bus.pc, 32'hC);
        chk("stall_bubble", {31'd0, bus.id_valid}, 32'd0);
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("stall_rel_id_pc", bus.id_pc, 32'hC);

        // flush beats branch and stall together
        drive(1'b0, 6'b000111, 1'b1, 32'h180, 1'b1, 32'h500);
        step();
        chk("flush_pc", bus.pc, 32'h180);
        chk("flush_id_valid", {31'd0, bus.id_valid}, 32'd0);

        // wrap past the top of the address space, then misaligned branch
        drive(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step();
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("wrap_pc", bus.pc, 32'h0);
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h42);
        step();
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("adel_flag", {31'd0, bus.id_adel}, 32'd1);
        chk("adel_inst", bus.id_inst, 32'h0);
        chk("adel_id_pc", bus.id_pc, 32'h42);
        chk("adel_valid", {31'd0, bus.id_valid}, 32'd1);

        // mid-run reset at pc=0x20 with competing controls
        drive(1'b0, 6'd0, 1'b1, 32'h20, 1'b0, 32'h0);
        step();
        drive(1'b1, 6'b000011, 1'b1, 32'h300, 1'b1, 32'h400);
        step();
        chk("mrst_pc", bus.pc, 32'h0);
        chk("mrst_ce", {31'd0, bus.ce}, 32'd0);
        chk("mrst_valid", {31'd0, bus.id_valid}, 32'd0);
        drive(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("mrst_c1_pc", bus.pc, 32'h0);
        step();
        chk("mrst_c2_pc", bus.pc, 32'h4);
        chk("mrst_c2_id_pc", bus.id_pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] npc;
            logic [31:0] tgt;
            npc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                  ($urandom_range(0, 15) == 0), npc,
                  ($urandom_range(0, 3) == 0), tgt);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
